// File: rtl/denorm_pipe.sv
// Three-stage uniform denormaliser: splits a double U in [0,1) into an index floor(U*2^W)
// and an exactly normalised remainder frac(U*2^W), with W chosen per sample by sel.
module denorm_pipe #(
   parameter int W0 = 10,
   parameter int W1 = 9,
   parameter int VW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pushin,
   input  logic          sel,
   input  logic [63:0]   num,
   output logic          pushout,
   output logic [VW-1:0] vin,
   output logic [63:0]   delta,
   output logic          err
);

   // The integer part never exceeds W <= VW bits, so 52 fraction bits plus VW suffice.
   localparam int SW = 52 + VW;
   localparam int LV = 5;

   typedef enum logic [1:0] {CLS_ZERO, CLS_SMALL, CLS_NORM, CLS_ERR} cls_t;

   // ---------------- stage 1: classify ----------------
   logic [10:0] e_in;
   logic [51:0] m_in;
   logic [10:0] w_in;
   logic [10:0] thr;
   cls_t        cls_next;
   logic [4:0]  k_next;
   logic [63:0] data_next;

   assign e_in   = num[62:52];
   assign m_in   = num[51:0];
   assign w_in   = sel ? 11'(W1) : 11'(W0);
   assign thr    = 11'd1023 - w_in;
   assign k_next = 5'(e_in - thr);

   always_comb begin
      cls_next  = CLS_NORM;
      data_next = {11'd0, 1'b1, m_in};
      if ((num[63] && num[62:0] != 63'd0) || e_in >= 11'd1023) begin
         cls_next  = CLS_ERR;
         data_next = '0;
      end else if (e_in == 11'd0) begin
         cls_next  = CLS_ZERO;
         data_next = '0;
      end else if (e_in < thr) begin
         // Below 2^-W: scaling by 2^W is just an exponent bump, and it cannot overflow.
         cls_next  = CLS_SMALL;
         data_next = {1'b0, e_in + w_in, m_in};
      end
   end

   logic        v1_reg;
   cls_t        cls1_reg;
   logic [4:0]  k1_reg;
   logic [63:0] data1_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg    <= 1'b0;
         cls1_reg  <= CLS_ZERO;
         k1_reg    <= '0;
         data1_reg <= '0;
      end else begin
         v1_reg    <= pushin;
         cls1_reg  <= cls_next;
         k1_reg    <= k_next;
         data1_reg <= data_next;
      end
   end

   // ---------------- stage 2: split ----------------
   logic [SW-1:0] lvl [0:LV];

   assign lvl[0] = SW'(data1_reg[52:0]);

   genvar gi;
   generate
      for (gi = 0; gi < LV; gi++) begin : g_shift
         assign lvl[gi+1] = k1_reg[gi] ? (lvl[gi] << (1 << gi)) : lvl[gi];
      end
   endgenerate

   logic          v2_reg;
   cls_t          cls2_reg;
   logic [VW-1:0] int2_reg;
   logic [63:0]   data2_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         v2_reg    <= 1'b0;
         cls2_reg  <= CLS_ZERO;
         int2_reg  <= '0;
         data2_reg <= '0;
      end else begin
         v2_reg    <= v1_reg;
         cls2_reg  <= cls1_reg;
         int2_reg  <= lvl[LV][SW-1:52];
         data2_reg <= (cls1_reg == CLS_NORM) ? {12'd0, lvl[LV][51:0]} : data1_reg;
      end
   end

   // ---------------- stage 3: normalise ----------------
   logic [51:0] rem;
   logic [5:0]  lzc;
   logic [51:0] frac_next;
   logic [63:0] delta_norm;

   assign rem = data2_reg[51:0];

   always_comb begin
      lzc = 6'd0;
      for (int i = 0; i < 52; i++) begin
         if (rem[i]) lzc = 6'(51 - i);
      end
   end

   // Shifting one past the leading one drops the hidden bit, leaving the mantissa.
   assign frac_next  = rem << (7'(lzc) + 7'd1);
   assign delta_norm = (rem == 52'd0) ? 64'd0
                     : {1'b0, 11'd1022 - {5'd0, lzc}, frac_next};

   logic          pushout_reg;
   logic [VW-1:0] vin_reg;
   logic [63:0]   delta_reg;
   logic          err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         pushout_reg <= 1'b0;
         vin_reg     <= '0;
         delta_reg   <= '0;
         err_reg     <= 1'b0;
      end else begin
         pushout_reg <= v2_reg;
         vin_reg     <= (v2_reg && cls2_reg == CLS_NORM) ? int2_reg : '0;
         if (v2_reg && cls2_reg == CLS_NORM)
            delta_reg <= delta_norm;
         else if (v2_reg && cls2_reg == CLS_SMALL)
            delta_reg <= data2_reg;
         else
            delta_reg <= '0;
         err_reg     <= v2_reg && (cls2_reg == CLS_ERR);
      end
   end

   assign pushout = pushout_reg;
   assign vin     = vin_reg;
   assign delta   = delta_reg;
   assign err     = err_reg;

endmodule

// File: tb/tb_denorm_pipe.sv
// Bench for denorm_pipe: directed table of known splits plus randomized streams checked
// against a real-arithmetic model delayed by the 3-cycle pipeline latency.
module tb_denorm_pipe;

   localparam int W0 = 10;
   localparam int W1 = 9;
   localparam int VW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          pushin;
   logic          sel;
   logic [63:0]   num;
   logic          pushout;
   logic [VW-1:0] vin;
   logic [63:0]   delta;
   logic          err;

   denorm_pipe #(.W0(W0), .W1(W1), .VW(VW)) dut (
      .clk(clk), .rst(rst), .pushin(pushin), .sel(sel), .num(num),
      .pushout(pushout), .vin(vin), .delta(delta), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          valid;
      logic [VW-1:0] vin;
      logic [63:0]   delta;
      logic          err;
   } exp_t;

   exp_t pipe [3];
   exp_t exp_now;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   localparam int NT = 17;
   logic [63:0]   t_num   [NT] = '{
      64'h3FE0000000000000, 64'h3FE8000000000000, 64'h3FE0020000000000, 64'h3FE0020000000000,
      64'h3EB0000000000000, 64'h0000000000000000, 64'h8000000000000000, 64'h3FF0000000000000,
      64'hBFE0000000000000, 64'h7FF8000000000000, 64'h3FEFFFFFFFFFFFFF, 64'h3F50000000000000,
      64'h3F40000000000000, 64'h0000000000000001, 64'h8000000000000001, 64'h3FEFFFFFFFFFFFFF,
      64'h3F50000000000000};
   logic          t_sel   [NT] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1};
   logic [VW-1:0] t_vin   [NT] = '{512, 384, 512, 256, 0, 0, 0, 0, 0, 0, 1023, 1, 0, 0, 0, 511, 0};
   logic [63:0]   t_delta [NT] = '{
      64'h0, 64'h0, 64'h3FD0000000000000, 64'h3FC0000000000000,
      64'h3F50000000000000, 64'h0, 64'h0, 64'h0,
      64'h0, 64'h0, 64'h3FEFFFFFFFFFFC00, 64'h0,
      64'h3FE0000000000000, 64'h0, 64'h0, 64'h3FEFFFFFFFFFFE00,
      64'h3FE0000000000000};
   logic          t_err   [NT] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0};

   // Reference: U*2^W computed in real arithmetic, which is exact for doubles in range.
   function automatic exp_t model(input logic [63:0] n, input logic s);
      exp_t        r;
      real         u, x, f;
      int          w;
      logic [10:0] e;
      r       = '0;
      r.valid = 1'b1;
      w       = s ? W1 : W0;
      e       = n[62:52];
      if ((n[63] && n[62:0] != 63'd0) || e >= 11'd1023) begin
         r.err = 1'b1;
      end else if (e != 11'd0) begin
         u       = $bitstoreal(n);
         x       = u * real'(longint'(1) << w);
         f       = $floor(x);
         r.vin   = VW'(longint'(f));
         r.delta = $realtobits(x - f);
      end
      return r;
   endfunction

   function automatic logic [63:0] rand_num();
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) return {$urandom(), $urandom()};
      if (k == 1) return {$urandom_range(0, 1) == 1, 63'd0};
      return {1'b0, 11'(1023 - $urandom_range(1, 25)), 20'($urandom()), $urandom()};
   endfunction

   // Drive one cycle of inputs, clock it, and advance the latency model.
   task automatic cycle(input logic p, input logic s, input logic [63:0] n, input logic r);
      rst    = r;
      pushin = p;
      sel    = s;
      num    = n;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         pipe[0] = '0;
         pipe[1] = '0;
         pipe[2] = '0;
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = p ? model(n, s) : '0;
      end
      exp_now = pipe[2];
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 64'h3FE0000000000000, 1'b1);
      cycle(1'b1, 1'b1, 64'h3FE8000000000000, 1'b1);
      n_vec++;
      if (pushout !== 1'b0 || vin !== '0 || delta !== 64'd0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got p=%b v=%0d d=%h e=%b, want all zero", pushout, vin, delta, err);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 64'd0, 1'b0);
         n_vec++;
         if (pushout !== 1'b0 || vin !== '0 || delta !== 64'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop c%0d: got p=%b v=%0d d=%h e=%b, want all zero",
                     i, pushout, vin, delta, err);
         end
      end
      $display("reset: idle outputs observed");
   endtask

   task automatic test_directed();
      for (int t = 0; t < NT; t++) begin
         cycle(1'b1, t_sel[t], t_num[t], 1'b0);
         cycle(1'b0, 1'b0, 64'd0, 1'b0);
         n_vec++;
         if (pushout !== 1'b0) begin
            n_bad++;
            $display("FAIL directed_early t%0d: pushout=%b want 0", t, pushout);
         end
         cycle(1'b0, 1'b0, 64'd0, 1'b0);
         n_vec++;
         if (pushout !== 1'b1 || vin !== t_vin[t] || delta !== t_delta[t] || err !== t_err[t]) begin
            n_bad++;
            $display("FAIL directed t%0d num=%h sel=%b: got p=%b v=%0d d=%h e=%b want p=1 v=%0d d=%h e=%b",
                     t, t_num[t], t_sel[t], pushout, vin, delta, err, t_vin[t], t_delta[t], t_err[t]);
         end
         $display("directed t%0d num=%h sel=%b -> v=%0d d=%h e=%b", t, t_num[t], t_sel[t], vin, delta, err);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 17; i++) begin
         if (i < 8)       cycle(1'b1, i[0], rand_num(), 1'b0);
         else if (i < 10) cycle(1'b0, 1'b0, rand_num(), 1'b0);
         else if (i < 14) cycle(1'b1, i[0], rand_num(), 1'b0);
         else             cycle(1'b0, 1'b0, 64'd0, 1'b0);
         n_vec++;
         if (pushout !== exp_now.valid || vin !== exp_now.vin || delta !== exp_now.delta ||
             err !== exp_now.err) begin
            n_bad++;
            $display("FAIL stream c%0d: got p=%b v=%0d d=%h e=%b want p=%b v=%0d d=%h e=%b", i,
                     pushout, vin, delta, err, exp_now.valid, exp_now.vin, exp_now.delta, exp_now.err);
         end
         $display("stream c%0d p=%b v=%0d d=%h e=%b", i, pushout, vin, delta, err);
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 9; i++) begin
         if (i < 3)       cycle(1'b1, 1'($urandom_range(0, 1)), rand_num(), 1'b0);
         else if (i == 3) cycle(1'b1, 1'b0, 64'h3FE0000000000000, 1'b1);
         else if (i == 4) cycle(1'b1, 1'b1, 64'h3FE8000000000000, 1'b0);
         else             cycle(1'b0, 1'b0, 64'd0, 1'b0);
         n_vec++;
         if (pushout !== exp_now.valid || vin !== exp_now.vin || delta !== exp_now.delta ||
             err !== exp_now.err) begin
            n_bad++;
            $display("FAIL midreset c%0d: got p=%b v=%0d d=%h e=%b want p=%b v=%0d d=%h e=%b", i,
                     pushout, vin, delta, err, exp_now.valid, exp_now.vin, exp_now.delta, exp_now.err);
         end
         $display("midreset c%0d p=%b v=%0d d=%h e=%b", i, pushout, vin, delta, err);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if (i < 297) cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), rand_num(), 1'b0);
         else         cycle(1'b0, 1'b0, 64'd0, 1'b0);
         n_vec++;
         if (pushout !== exp_now.valid || vin !== exp_now.vin || delta !== exp_now.delta ||
             err !== exp_now.err) begin
            n_bad++;
            $display("FAIL random c%0d: got p=%b v=%0d d=%h e=%b want p=%b v=%0d d=%h e=%b", i,
                     pushout, vin, delta, err, exp_now.valid, exp_now.vin, exp_now.delta, exp_now.err);
         end
         if (pushout) $display("random c%0d v=%0d d=%h e=%b", i, vin, delta, err);
      end
   endtask

   initial begin
      rst    = 1'b1;
      pushin = 1'b0;
      sel    = 1'b0;
      num    = 64'd0;
      pipe[0] = '0;
      pipe[1] = '0;
      pipe[2] = '0;
      exp_now = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/denorm_pipe.md
Name: denorm_pipe

Overview:
- Pipelined, parametrised successor to the Box-Muller uniform denormaliser.
- Takes an IEEE 754 double U in [0,1) and splits it into a table index vin = floor(U·2^W) and a normalised double delta = frac(U·2^W) for interpolation.
- W is selected per sample: U1 path (sel=0) uses W0, U2 path (sel=1) uses W1.
- Sits between the uniform RNG and the log/sqrt and sin/cos coefficient lookup stages. Accepts one sample per clock.

Parameters:
- W0, 10, index width for sel=0 (U1); legal range 1..20.
- W1, 9, index width for sel=1 (U2); legal range 1..20.
- VW, 10, vin port width; must be >= max(W0,W1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pushin  in  1  input sample valid this cycle.
- sel  in  1  0 = U1/W0, 1 = U2/W1; sampled with pushin.
- num  in  64  IEEE 754 double U.
- pushout  out  1  output valid.
- vin  out  VW  index, zero-extended from W bits.
- delta  out  64  normalised double remainder in [0,1).
- err  out  1  input out of range; qualified by pushout.

Behaviour:
- Reset: synchronous, active-high. On a clock edge with rst=1, all pipeline valid bits clear and pushout, vin, delta, err all become 0. Samples in flight are discarded. A pushin asserted in the rst cycle is dropped. First accept is in the first cycle with rst=0.
- Throughput and latency: no backpressure; a sample is accepted on every cycle with pushin=1. Fixed latency of 3: pushin at edge n gives pushout=1 with results after edge n+3. Order is preserved. Bubbles propagate unchanged.
- Output gating: when pushout=0, vin, delta and err are driven to 0.
- Stage 1 (classify): latch sel, sign s, exponent e, mantissa m. Let W = sel ? W1 : W0. Classify the sample:
  - err class: s=1 and num is not ±0, or e >= 1023 (U >= 1, Inf, NaN).
  - zero class: e == 0 (zero, −0, or subnormal).
  - small class: 0 < e < 1023−W, so U < 2^-W.
  - normal class: otherwise. Compute shift k = e − (1023−W), range 0..W−1.
- Stage 2 (split): for normal class, form the 53-bit significand 1.m and left-shift it by k with a barrel shifter of ceil(log2(20)) levels.
  - vin = top W bits of the integer part (U·2^W).
  - The remaining fraction bits (53−1−k of them) form the remainder.
- Stage 3 (normalise): leading-zero count on the remainder, shift left, and build delta with sign 0, exponent 1022 − lzc, mantissa equal to the bits below the leading one. The result is exact; no rounding occurs.
  - remainder == 0: delta = 0x0000000000000000.
- Small class: vin = 0, delta = num with exponent field increased by W (exact scale by 2^W).
- Zero class: vin = 0, delta = 0, err = 0.
- Err class: vin = 0, delta = 0, err = 1.
- −0.0 belongs to the zero class, not the err class.
- Mixed sel values in consecutive cycles must each use their own W. No sel state is retained between samples.

Test Plan:
- Exact index, W0=10, W1=9: num=0x3FE0000000000000 (0.5), sel=0 → 3 cycles later pushout=1, vin=512, delta=0, err=0. num=0x3FE8000000000000 (0.75), sel=1 → vin=384, delta=0.
- Fractional remainder: num=0x3FE0020000000000 (0.5+2^-12), sel=0 → vin=512, delta=0x3FD0000000000000 (0.25). Same num with sel=1 → vin=256, delta=0x3FC0000000000000 (0.125).
- Small and zero classes: num=0x3EB0000000000000 (2^-20), sel=0 → vin=0, delta=0x3F50000000000000 (2^-10). num=0x0 and num=0x8000000000000000 → vin=0, delta=0, err=0.
- Error class: num=0x3FF0000000000000 (1.0), 0xBFE0000000000000 (−0.5), 0x7FF8000000000000 (NaN) → err=1, vin=0, delta=0 in each case.
- Streaming: 8 back-to-back pushes with alternating sel, then a 2-cycle pushin gap, then 4 more pushes → pushout shows the same 8-valid / 2-idle / 4-valid pattern delayed by 3 cycles. Every result matches a golden model computed in real arithmetic.
- Reset mid-flight: assert rst for 1 cycle while 3 samples are in flight → pushout stays 0 for the next 3 cycles and all outputs are 0. A push issued in the first post-reset cycle appears exactly 3 cycles later.
